// File: rtl/fc_result_argmax.sv
// Collects one frame of signed FC3 logits, tracks the running argmax,
// publishes the winning class and score, and offers registered logit readback.
module fc_result_argmax #(
   parameter int DATA_WIDTH_OUT = 32,
   parameter int NUM_CLASS      = 10,
   parameter int IDX_WIDTH      = 4
) (
   input  logic                      clk1,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH_OUT-1:0] in_data,
   input  logic [IDX_WIDTH-1:0]      rd_addr,
   output logic [DATA_WIDTH_OUT-1:0] rd_data,
   output logic [IDX_WIDTH-1:0]      class_idx,
   output logic [DATA_WIDTH_OUT-1:0] class_score,
   output logic                      result_valid,
   output logic                      busy,
   output logic                      seq_err
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);
   localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

   state_t                     state;
   logic [IDX_WIDTH-1:0]       cnt;
   logic [DATA_WIDTH_OUT-1:0]  run_max;
   logic [IDX_WIDTH-1:0]       run_idx;
   logic [DATA_WIDTH_OUT-1:0]  logit_mem [NUM_CLASS];

   logic                       take;
   logic [DATA_WIDTH_OUT-1:0]  nxt_max;
   logic [IDX_WIDTH-1:0]       nxt_idx;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      take    = 1'b0;
      nxt_max = run_max;
      nxt_idx = run_idx;
      if ((cnt == '0) || ($signed(in_data) > $signed(run_max)))
         take = 1'b1;
      if (take) begin
         nxt_max = in_data;
         nxt_idx = cnt;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         run_max      <= '0;
         run_idx      <= '0;
         class_idx    <= '0;
         class_score  <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         seq_err      <= 1'b0;
      end else if (start) begin
         state        <= COLLECT;
         cnt          <= '0;
         run_max      <= '0;
         run_idx      <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b1;
         seq_err      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid)
                  seq_err <= 1'b1;
            end
            COLLECT: begin
               if (in_valid) begin
                  run_max <= nxt_max;
                  run_idx <= nxt_idx;
                  if (cnt == LAST_IDX) begin
                     state        <= DONE;
                     cnt          <= '0;
                     class_idx    <= nxt_idx;
                     class_score  <= nxt_max;
                     result_valid <= 1'b1;
                     busy         <= 1'b0;
                  end else begin
                     cnt <= cnt + ONE_IDX;
                  end
               end
            end
            DONE: begin
               if (in_valid)
                  seq_err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Buffer and readback; a same-cycle read sees the pre-write value.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         for (int i = 0; i < NUM_CLASS; i++)
            logit_mem[i] <= '0;
      end else begin
         if (rd_addr <= LAST_IDX)
            rd_data <= logit_mem[rd_addr];
         else
            rd_data <= '0;
         if (!start && in_valid && (state == COLLECT))
            logit_mem[cnt] <= in_data;
      end
   end

endmodule

// File: tb/tb_fc_result_argmax.sv
// Scoreboard bench for fc_result_argmax: expected results are queued as
// frames are driven and compared whenever result_valid is seen.
module tb_fc_result_argmax;

   logic        clk1;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [3:0]  class_idx;
   logic [31:0] class_score;
   logic        result_valid;
   logic        busy;
   logic        seq_err;

   int errs;
   int checks;
   int pulses;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] score;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] frm [10];
   logic [31:0] exp_mem [10];

   fc_result_argmax #(
      .DATA_WIDTH_OUT(32),
      .NUM_CLASS(10),
      .IDX_WIDTH(4)
   ) dut (
      .clk1(clk1),
      .rst_n(rst_n),
      .start(start),
      .in_valid(in_valid),
      .in_data(in_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .class_idx(class_idx),
      .class_score(class_score),
      .result_valid(result_valid),
      .busy(busy),
      .seq_err(seq_err)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk1) begin
      if (rst_n && result_valid) begin
         res_t r;
         pulses++;
         if (exp_q.size() == 0) begin
            check("spurious_pulse", 1, 0);
         end else begin
            r = exp_q.pop_front();
            check("sb_idx", {60'd0, class_idx}, {60'd0, r.idx});
            check("sb_score", {32'd0, class_score}, {32'd0, r.score});
         end
      end
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Drives frm[] as one frame; the model result is queued with the last logit.
   task automatic run_frame(input int maxgap);
      res_t r;
      r.idx   = 4'd0;
      r.score = frm[0];
      for (int i = 1; i < 10; i++)
         if ($signed(frm[i]) > $signed(r.score)) begin
            r.idx   = 4'(i);
            r.score = frm[i];
         end
      for (int i = 0; i < 10; i++) begin
         if (i == 9)
            exp_q.push_back(r);
         exp_mem[i] = frm[i];
         send(frm[i]);
         if (i < 9)
            repeat ($urandom_range(0, maxgap)) tick();
      end
   endtask

   initial begin
      int p0;
      errs     = 0;
      checks   = 0;
      pulses   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      rd_addr  = '0;
      repeat (3) tick();
      check("rst_idx", {60'd0, class_idx}, 0);
      check("rst_score", {32'd0, class_score}, 0);
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_rv", {63'd0, result_valid}, 0);
      rst_n = 1'b1;
      tick();

      // T1
      pulse_start();
      check("t1_busy", {63'd0, busy}, 1);
      frm = '{32'd5, -32'sd3, 32'd12, 32'd0, 32'd7,
              32'd1, 32'd2, 32'd40, -32'sd8, 32'd9};
      run_frame(0);
      check("t1_rv", {63'd0, result_valid}, 1);
      check("t1_busy_fall", {63'd0, busy}, 0);
      check("t1_idx", {60'd0, class_idx}, 7);
      check("t1_score", {32'd0, class_score}, 40);
      check("t1_seq", {63'd0, seq_err}, 0);
      tick();
      check("t1_rv_off", {63'd0, result_valid}, 0);

      // T5
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         tick();
         check($sformatf("t5_rd%0d", a), {32'd0, rd_data},
               {32'd0, (a < 10) ? exp_mem[a] : 32'd0});
      end

      // T3
      send(32'd99);
      check("t3_seq", {63'd0, seq_err}, 1);
      check("t3_idx", {60'd0, class_idx}, 7);
      pulse_start();
      check("t3_seq_clr", {63'd0, seq_err}, 0);

      // T2 (start already issued)
      p0 = pulses;
      frm = '{-32'sd100, -32'sd7, -32'sd50, -32'sd7, -32'sd9,
              -32'sd200, -32'sd300, -32'sd8, -32'sd7, -32'sd1000};
      run_frame(3);
      repeat (3) tick();
      check("t2_idx", {60'd0, class_idx}, 1);
      check("t2_score", {32'd0, class_score}, {32'd0, -32'sd7});
      check("t2_pulses", 64'(pulses - p0), 1);

      // T4
      p0 = pulses;
      pulse_start();
      for (int i = 0; i < 4; i++) send(32'd1000 + 32'(i));
      check("t4_idx_hold", {60'd0, class_idx}, 1);
      pulse_start();
      frm = '{32'd3, 32'd8, -32'sd1, 32'd100, 32'd2,
              32'd5, 32'd6, 32'd7, 32'd9, 32'h7FFF_FFFF};
      run_frame(1);
      repeat (3) tick();
      check("t4_idx", {60'd0, class_idx}, 9);
      check("t4_score", {32'd0, class_score}, 64'd2147483647);
      check("t4_pulses", 64'(pulses - p0), 1);

      // T6
      pulse_start();
      for (int i = 0; i < 5; i++) send(32'd500 + 32'(i));
      rd_addr = 4'd0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_idx", {60'd0, class_idx}, 0);
      check("t6_score", {32'd0, class_score}, 0);
      check("t6_busy", {63'd0, busy}, 0);
      check("t6_seq", {63'd0, seq_err}, 0);
      check("t6_rd", {32'd0, rd_data}, 0);
      check("t6_rv", {63'd0, result_valid}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_mem_clr", {32'd0, rd_data}, 0);
      pulse_start();
      frm = '{-32'sd5, 32'd20, 32'd3, 32'd20, 32'd1,
              32'd0, -32'sd2, 32'd19, 32'd4, 32'd6};
      run_frame(2);
      repeat (3) tick();
      check("t6_idx2", {60'd0, class_idx}, 1);
      check("t6_score2", {32'd0, class_score}, 20);
      rd_addr = 4'd4;
      tick();
      check("t6_rd4", {32'd0, rd_data}, 1);

      check("sb_drained", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
